// File: rtl/edge_event_recorder.sv
// Edge event recorder: timestamps per-cycle edge masks of N_CH synchronous inputs
// and queues them in a DEPTH-entry FIFO, counting entries lost to a full queue.
module edge_event_recorder #(
   parameter int N_CH  = 4,
   parameter int TS_W  = 16,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_CH-1:0]            sig_in,
   input  logic                       en,
   input  logic                       clr,
   output logic                       evt_valid,
   input  logic                       evt_ready,
   output logic [TS_W+2*N_CH-1:0]     evt_data,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   output logic [7:0]                 drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int EW = TS_W + 2*N_CH;

   logic [N_CH-1:0] prev_q;
   logic [TS_W-1:0] ts_q, ts_d;
   logic [EW-1:0]   mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic            overflow_q, overflow_d;
   logic [7:0]      drop_cnt_q, drop_cnt_d;

   logic [N_CH-1:0] rise, fall;
   logic            has_edge, full, push, pop, drop;

   assign rise     = sig_in & ~prev_q;
   assign fall     = ~sig_in & prev_q;
   assign has_edge = |(rise | fall);
   assign full     = (level_q == LW'(DEPTH));

   // Outputs are masked during reset so they read idle before the first reset edge lands.
   assign evt_valid = ~rst && (level_q != '0);
   assign evt_data  = evt_valid ? mem_q[rd_ptr_q] : '0;
   assign level     = rst ? '0 : level_q;
   assign overflow  = rst ? 1'b0 : overflow_q;
   assign drop_cnt  = rst ? 8'd0 : drop_cnt_q;

   assign pop  = evt_valid & evt_ready;
   assign push = ~rst & en & has_edge & (~full | pop);
   assign drop = ~rst & en & has_edge & full & ~pop;

   always_comb begin
      ts_d       = ts_q + 1'b1;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q | drop;
      drop_cnt_d = drop_cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;
      if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 1'b1;
      // A drop coinciding with clr survives the clear.
      if (clr) begin
         overflow_d = drop;
         drop_cnt_d = drop ? 8'd1 : 8'd0;
      end
   end

   always_ff @(posedge clk) begin
      prev_q <= sig_in;
      if (rst) begin
         ts_q       <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= 8'd0;
      end else begin
         ts_q       <= ts_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {ts_q, rise, fall};
   end

endmodule

// File: tb/tb_edge_event_recorder.sv
// Directed bench for edge_event_recorder: inputs change 1ns after the rising edge,
// outputs are sampled 1ns later, well before the next edge.
module tb_edge_event_recorder;

   logic        clk = 1'b0;
   logic        rst, en, clr, evt_ready;
   logic [3:0]  sig_in;
   logic        evt_valid, overflow;
   logic [23:0] evt_data;
   logic [3:0]  level;
   logic [7:0]  drop_cnt;

   int checks = 0;
   int errors = 0;

   edge_event_recorder #(.N_CH(4), .TS_W(16), .DEPTH(8)) dut (
      .clk(clk), .rst(rst), .sig_in(sig_in), .en(en), .clr(clr),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
      .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench 1ns into cycle 0 (ts=0) with rst low.
   task automatic do_reset(input logic [3:0] s);
      rst = 1'b1; sig_in = s; clr = 1'b0;
      tick;
      tick;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; sig_in = 4'b0000; en = 1'b0; clr = 1'b0; evt_ready = 1'b0;
      tick;
      #1;
      checks++;
      if (evt_valid !== 1'b0 || level !== 4'd0 || overflow !== 1'b0 ||
          drop_cnt !== 8'd0 || evt_data !== 24'd0) begin
         errors++;
         $display("FAIL reset_state: valid=%b level=%0d ovf=%b drop=%0d data=%h, want 0 0 0 0 000000",
                  evt_valid, level, overflow, drop_cnt, evt_data);
      end
      tick;
      rst = 1'b0;
      #1;
      checks++;
      if (evt_valid !== 1'b0 || level !== 4'd0) begin
         errors++;
         $display("FAIL reset_release: valid=%b level=%0d, want 0 0", evt_valid, level);
      end
   endtask

   task automatic test_single_edge;
      do_reset(4'b0000);
      en = 1'b1; evt_ready = 1'b1;
      repeat (5) tick;
      sig_in = 4'b0001;
      #1;
      checks++;
      if (evt_valid !== 1'b0) begin
         errors++; $display("FAIL single_pre_valid: got %b want 0", evt_valid);
      end
      tick; #1;
      checks++;
      if (evt_valid !== 1'b1 || evt_data !== {16'd5, 4'b0001, 4'b0000}) begin
         errors++;
         $display("FAIL single_entry: valid=%b data=%h, want 1 %h", evt_valid, evt_data,
                  {16'd5, 4'b0001, 4'b0000});
      end
      tick; #1;
      checks++;
      if (evt_valid !== 1'b0) begin
         errors++; $display("FAIL single_pulse: valid=%b want 0", evt_valid);
      end
   endtask

   task automatic test_simultaneous;
      do_reset(4'b0011);
      en = 1'b1; evt_ready = 1'b1;
      repeat (10) tick;
      sig_in = 4'b0101;
      #1;
      checks++;
      if (level !== 4'd0) begin
         errors++; $display("FAIL simul_pre_level: got %0d want 0", level);
      end
      tick; #1;
      checks++;
      if (evt_valid !== 1'b1 || level !== 4'd1 || evt_data !== {16'd10, 4'b0100, 4'b0010}) begin
         errors++;
         $display("FAIL simul_entry: valid=%b level=%0d data=%h, want 1 1 %h", evt_valid, level,
                  evt_data, {16'd10, 4'b0100, 4'b0010});
      end
      tick; #1;
      checks++;
      if (evt_valid !== 1'b0 || level !== 4'd0) begin
         errors++; $display("FAIL simul_drain: valid=%b level=%0d, want 0 0", evt_valid, level);
      end
   endtask

   task automatic test_overflow_and_full_pushpop;
      logic [23:0] exp;
      do_reset(4'b0000);
      en = 1'b1; evt_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         sig_in[1] = ~sig_in[1];
         tick;
      end
      sig_in = 4'b0000;
      #1;
      checks++;
      if (level !== 4'd8 || overflow !== 1'b1 || drop_cnt !== 8'd2) begin
         errors++;
         $display("FAIL overflow_fill: level=%0d ovf=%b drop=%0d, want 8 1 2", level, overflow, drop_cnt);
      end
      clr = 1'b1;
      tick;
      clr = 1'b0;
      #1;
      checks++;
      if (level !== 4'd8 || overflow !== 1'b0 || drop_cnt !== 8'd0) begin
         errors++;
         $display("FAIL overflow_clr: level=%0d ovf=%b drop=%0d, want 8 0 0", level, overflow, drop_cnt);
      end
      // Cycle 11: full FIFO, pop and a new rise together.
      evt_ready = 1'b1;
      sig_in[1] = 1'b1;
      #1;
      checks++;
      if (evt_data !== {16'd0, 4'b0010, 4'b0000}) begin
         errors++; $display("FAIL order_head0: got %h want %h", evt_data, {16'd0, 4'b0010, 4'b0000});
      end
      tick; #1;
      checks++;
      if (level !== 4'd8 || drop_cnt !== 8'd0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL full_pushpop: level=%0d drop=%0d ovf=%b, want 8 0 0", level, drop_cnt, overflow);
      end
      for (int j = 1; j < 8; j++) begin
         exp = {16'(j), (j % 2 == 0) ? 4'b0010 : 4'b0000, (j % 2 == 0) ? 4'b0000 : 4'b0010};
         checks++;
         if (evt_valid !== 1'b1 || evt_data !== exp) begin
            errors++;
            $display("FAIL order_entry%0d: valid=%b data=%h, want 1 %h", j, evt_valid, evt_data, exp);
         end
         tick; #1;
      end
      checks++;
      if (evt_valid !== 1'b1 || level !== 4'd1 || evt_data !== {16'd11, 4'b0010, 4'b0000}) begin
         errors++;
         $display("FAIL full_newest_last: valid=%b level=%0d data=%h, want 1 1 %h", evt_valid, level,
                  evt_data, {16'd11, 4'b0010, 4'b0000});
      end
      tick; #1;
      checks++;
      if (evt_valid !== 1'b0 || level !== 4'd0) begin
         errors++; $display("FAIL full_drained: valid=%b level=%0d, want 0 0", evt_valid, level);
      end
   endtask

   task automatic test_clr_drop_and_saturate;
      do_reset(4'b0000);
      en = 1'b1; evt_ready = 1'b0;
      repeat (9) begin
         sig_in[1] = ~sig_in[1];
         tick;
      end
      #1;
      checks++;
      if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin
         errors++; $display("FAIL drop_one: ovf=%b drop=%0d, want 1 1", overflow, drop_cnt);
      end
      sig_in[1] = ~sig_in[1];
      clr = 1'b1;
      tick;
      clr = 1'b0;
      #1;
      checks++;
      if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin
         errors++; $display("FAIL clr_with_drop: ovf=%b drop=%0d, want 1 1", overflow, drop_cnt);
      end
      repeat (260) begin
         sig_in[1] = ~sig_in[1];
         tick;
      end
      #1;
      checks++;
      if (drop_cnt !== 8'd255 || overflow !== 1'b1 || level !== 4'd8) begin
         errors++;
         $display("FAIL drop_saturate: drop=%0d ovf=%b level=%0d, want 255 1 8", drop_cnt, overflow, level);
      end
   endtask

   task automatic test_enable_gating;
      int bad;
      bad = 0;
      do_reset(4'b0000);
      en = 1'b0; evt_ready = 1'b1;
      tick;
      sig_in[2] = 1'b1;
      tick;
      en = 1'b1;
      repeat (6) begin
         #1;
         if (evt_valid !== 1'b0 || level !== 4'd0 || overflow !== 1'b0) bad++;
         tick;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL enable_gating: %0d cycles showed an entry, want 0", bad);
      end
   endtask

   task automatic test_reset_midstream;
      do_reset(4'b0000);
      en = 1'b1; evt_ready = 1'b0;
      repeat (3) begin
         sig_in[0] = ~sig_in[0];
         tick;
      end
      #1;
      checks++;
      if (level !== 4'd3) begin
         errors++; $display("FAIL mid_queued: level=%0d want 3", level);
      end
      rst = 1'b1; sig_in = 4'b1111;
      #1;
      checks++;
      if (evt_valid !== 1'b0 || level !== 4'd0 || evt_data !== 24'd0) begin
         errors++;
         $display("FAIL mid_in_reset: valid=%b level=%0d data=%h, want 0 0 000000", evt_valid, level, evt_data);
      end
      tick;
      rst = 1'b0;
      #1;
      checks++;
      if (evt_valid !== 1'b0 || level !== 4'd0) begin
         errors++; $display("FAIL mid_release: valid=%b level=%0d, want 0 0", evt_valid, level);
      end
      tick;
      tick;
      sig_in[3] = 1'b0;
      evt_ready = 1'b1;
      tick; #1;
      checks++;
      if (evt_valid !== 1'b1 || evt_data !== {16'd2, 4'b0000, 4'b1000}) begin
         errors++;
         $display("FAIL mid_ts_restart: valid=%b data=%h, want 1 %h", evt_valid, evt_data,
                  {16'd2, 4'b0000, 4'b1000});
      end
   endtask

   initial begin
      test_reset;
      test_single_edge;
      test_simultaneous;
      test_overflow_and_full_pushpop;
      test_clr_drop_and_saturate;
      test_enable_gating;
      test_reset_midstream;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
